// File: rtl/serial_compare_driver.sv
// serial_compare_driver: streams two operands LSB first to a bit-serial comparator and latches its g/e/l verdict
module serial_compare_driver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             g_in,
  input  logic             e_in,
  input  logic             l_in,
  output logic             cmp_reset,
  output logic             x_out,
  output logic             y_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic             result_g,
  output logic             result_e,
  output logic             result_l,
  output logic             error
);
  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, CAPTURE} state_t;
  state_t state;
  logic [WIDTH-1:0] sh_a, sh_b, nxt_a, nxt_b;
  logic [CNT_W-1:0] cnt;
  always_comb begin
    nxt_a = sh_a >> 1;
    nxt_b = sh_b >> 1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sh_a <= '0;
      sh_b <= '0;
      cnt <= '0;
      cmp_reset <= 1'b0;
      x_out <= 1'b0;
      y_out <= 1'b0;
      bit_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      result_g <= 1'b0;
      result_e <= 1'b0;
      result_l <= 1'b0;
      error <= 1'b0;
    end else begin
      cmp_reset <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sh_a <= a_in;
          sh_b <= b_in;
          cnt <= '0;
          cmp_reset <= 1'b1;
          busy <= 1'b1;
          state <= CLEAR;
        end
        CLEAR: begin
          bit_valid <= 1'b1;
          x_out <= sh_a[0];
          y_out <= sh_b[0];
          state <= SHIFT;
        end
        SHIFT: begin
          sh_a <= nxt_a;
          sh_b <= nxt_b;
          cnt <= cnt + CNT_W'(1);
          bit_valid <= cnt != CNT_W'(WIDTH - 1);
          x_out <= (cnt != CNT_W'(WIDTH - 1)) ? nxt_a[0] : 1'b0;
          y_out <= (cnt != CNT_W'(WIDTH - 1)) ? nxt_b[0] : 1'b0;
          state <= (cnt == CNT_W'(WIDTH - 1)) ? CAPTURE : SHIFT;
        end
        CAPTURE: begin
          {result_g, result_e, result_l} <= {g_in, e_in, l_in};
          error <= !((g_in ^ e_in ^ l_in) && !(g_in && e_in && l_in));
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_compare_driver.sv
// tb_serial_compare_driver: randomized check of the serial compare initiator against an arithmetic model
module tb_serial_compare_driver;
  localparam int W = 4;
  logic clk = 0, reset = 1, start = 0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic g_in, e_in, l_in;
  logic cmp_reset, x_out, y_out, bit_valid, busy, done;
  logic result_g, result_e, result_l, error;
  logic cg = 0, ce = 1, cl = 0, inj = 0;
  int tests = 0, fails = 0;

  serial_compare_driver #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .g_in(g_in), .e_in(e_in), .l_in(l_in), .cmp_reset(cmp_reset),
    .x_out(x_out), .y_out(y_out), .bit_valid(bit_valid), .busy(busy),
    .done(done), .result_g(result_g), .result_e(result_e),
    .result_l(result_l), .error(error)
  );

  always #5 clk = ~clk;

  // Serial comparator stand-in; inj forces a non-one-hot verdict
  always @(posedge clk)
    if (cmp_reset) begin
      cg <= 0; ce <= 1; cl <= 0;
    end else if (bit_valid && x_out != y_out) begin
      cg <= x_out; ce <= 0; cl <= y_out;
    end
  assign g_in = cg | inj;
  assign e_in = ce | inj;
  assign l_in = cl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".outs"}, {cmp_reset, x_out, y_out, bit_valid, busy, done}, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_quiet("idle");
    end
  endtask

  // Called just after a negedge; returns at the negedge of the done cycle.
  task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input bit bad, input int sp);
    a_in = a; b_in = b; start = 1;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      start = 0;
      inj = 0;
      check("cmp_reset", cmp_reset, k == 1);
      check("busy", busy, k <= W + 2);
      check("bit_valid", bit_valid, k >= 2 && k <= W + 1);
      check("done", done, k == W + 3);
      if (k >= 2 && k <= W + 1) begin
        check("x_bit", x_out, (a >> (k - 2)) & 1);
        check("y_bit", y_out, (b >> (k - 2)) & 1);
      end else
        check("xy_idle", {x_out, y_out}, 0);
      if (k == W + 3) begin
        check("result", {result_g, result_e, result_l}, {(a > b) | bad, (a == b) | bad, a < b});
        check("error", error, bad);
      end
      if (k == W + 2) inj = bad;
      if (k == sp) begin
        start = 1; a_in = ~a; b_in = ~b;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check("reset.res", {result_g, result_e, result_l, error}, 0);
    reset = 0;
    @(negedge clk);
    txn(5, 3, 0, 0);
    idle(2);
    txn(9, 9, 0, 0);
    idle(1);
    txn(2, 12, 0, 0);
    idle(1);
    txn(15, 0, 0, 3);
    idle(3);
    // abort in the third SHIFT cycle
    a_in = 15; b_in = 0; start = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 0;
    end
    check("abort.busy", busy, 1);
    reset = 1;
    @(negedge clk);
    check_quiet("abort");
    check("abort.res", {result_g, result_e, result_l, error}, 0);
    reset = 0;
    idle(3);
    txn(1, 1, 0, 0);
    idle(1);
    txn(6, 2, 1, 0);
    idle(1);
    txn(4, 4, 0, 0);
    txn(3, 7, 0, 0);
    idle(1);
    for (int i = 0; i < 40; i++) begin
      txn(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), $urandom_range(0, 7) == 0,
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 2)) : 0);
      if ($urandom_range(0, 1)) idle($urandom_range(1, 3));
    end
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
